// File: rtl/branch_resolve_unit_pkg.sv
// rtl/branch_resolve_unit_pkg.sv - shared encodings for the branch resolve unit
package branch_resolve_unit_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_REDIRECT = 1'b1
  } state_e;

endpackage

// File: rtl/branch_resolve_unit_cond.sv
// rtl/branch_resolve_unit_cond.sv - funct3 + SUB flags -> branch condition / illegal
module branch_cond_eval
  import branch_resolve_unit_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       negative,
  input  logic       overflow,
  input  logic       carry,
  output logic       cond,
  output logic       illegal
);

  logic lt;

  always_comb begin
    // carry is no-borrow for rs1 - rs2, so carry=1 means rs1 >= rs2 unsigned
    lt      = negative ^ overflow;
    cond    = 1'b0;
    illegal = 1'b0;
    case (funct3)
      BR_EQ:   cond = zero;
      BR_NE:   cond = ~zero;
      BR_LT:   cond = lt;
      BR_GE:   cond = ~lt;
      BR_LTU:  cond = ~carry;
      BR_GEU:  cond = carry;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - EX branch/jump resolution, registered PC redirect, flush, stats
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic             ex_branch,
  input  logic             ex_jump,
  input  logic [2:0]       ex_funct3,
  input  logic             zero,
  input  logic             negative,
  input  logic             overflow,
  input  logic             carry,
  input  logic [XLEN-1:0]  ex_target,
  output logic             redirect_valid,
  input  logic             redirect_ready,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             misalign_err,
  output logic             illegal_br,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] taken_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              misalign_q, misalign_d;
  logic              illegal_q, illegal_d;
  logic [CNT_W-1:0]  br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0]  tk_cnt_q, tk_cnt_d;
  logic              cond, illegal, take;

  branch_cond_eval u_cond (
    .funct3   (ex_funct3),
    .zero     (zero),
    .negative (negative),
    .overflow (overflow),
    .carry    (carry),
    .cond     (cond),
    .illegal  (illegal)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    misalign_d = 1'b0;
    illegal_d  = 1'b0;
    br_cnt_d   = br_cnt_q;
    tk_cnt_d   = tk_cnt_q;
    take       = ex_valid & (ex_jump | (ex_branch & cond));
    case (state_q)
      ST_IDLE: begin
        if (ex_valid & ex_branch & ~ex_jump & (br_cnt_q != CNT_MAX))
          br_cnt_d = br_cnt_q + CNT_ONE;
        illegal_d = ex_valid & ex_branch & illegal;
        if (take) begin
          if (ex_target[1:0] == 2'b00) begin
            state_d = ST_REDIRECT;
            pc_d    = ex_target;
            if (tk_cnt_q != CNT_MAX) tk_cnt_d = tk_cnt_q + CNT_ONE;
          end else begin
            misalign_d = 1'b1;
          end
        end
      end
      // EX contents are wrong-path while a redirect is outstanding
      ST_REDIRECT: begin
        if (redirect_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= '0;
      misalign_q <= 1'b0;
      illegal_q  <= 1'b0;
      br_cnt_q   <= '0;
      tk_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
      illegal_q  <= illegal_d;
      br_cnt_q   <= br_cnt_d;
      tk_cnt_q   <= tk_cnt_d;
    end
  end

  assign redirect_valid = (state_q == ST_REDIRECT);
  assign flush_if_id    = (state_q == ST_REDIRECT);
  assign flush_id_ex    = (state_q == ST_REDIRECT);
  assign redirect_pc    = pc_q;
  assign misalign_err   = misalign_q;
  assign illegal_br     = illegal_q;
  assign br_count       = br_cnt_q;
  assign taken_count    = tk_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - randomized + directed bench with reference model
module tb_branch_resolve_unit;

  localparam int XLEN  = 32;
  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic clk = 1'b0;
  logic rst;
  logic ex_valid, ex_branch, ex_jump, redirect_ready;
  logic [2:0] ex_funct3;
  logic [31:0] rs1, rs2, ex_target, diff;
  logic zero, negative, overflow, carry;
  logic redirect_valid, flush_if_id, flush_id_ex, misalign_err, illegal_br;
  logic [31:0] redirect_pc;
  logic [CNT_W-1:0] br_count, taken_count;

  always #5 clk = ~clk;

  assign diff     = rs1 - rs2;
  assign zero     = (diff == 32'd0);
  assign negative = diff[31];
  assign overflow = (rs1[31] != rs2[31]) && (diff[31] != rs1[31]);
  assign carry    = (rs1 >= rs2);

  branch_resolve_unit #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_jump(ex_jump),
    .ex_funct3(ex_funct3), .zero(zero), .negative(negative), .overflow(overflow), .carry(carry),
    .ex_target(ex_target), .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
    .redirect_pc(redirect_pc), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .misalign_err(misalign_err), .illegal_br(illegal_br), .br_count(br_count),
    .taken_count(taken_count)
  );

  bit m_redir, m_mis, m_ill;
  logic [31:0] m_pc;
  logic [CNT_W-1:0] m_br, m_tk;
  int errors = 0;
  int checks = 0;

  function automatic logic [52:0] dut_vec();
    return {redirect_valid, redirect_pc, flush_if_id, flush_id_ex, misalign_err, illegal_br,
            br_count, taken_count};
  endfunction

  function automatic logic [52:0] model_vec();
    return {m_redir, m_pc, m_redir, m_redir, m_mis, m_ill, m_br, m_tk};
  endfunction

  task automatic model_reset();
    m_redir = 0; m_mis = 0; m_ill = 0; m_pc = '0; m_br = '0; m_tk = '0;
  endtask

  // Branch outcome straight from operand comparison, not from flags
  task automatic model_clock();
    bit c, tk;
    m_mis = 0;
    m_ill = 0;
    if (m_redir) begin
      if (redirect_ready) m_redir = 0;
    end else if (ex_valid) begin
      case (ex_funct3)
        3'd0: c = (rs1 == rs2);
        3'd1: c = (rs1 != rs2);
        3'd4: c = ($signed(rs1) < $signed(rs2));
        3'd5: c = ($signed(rs1) >= $signed(rs2));
        3'd6: c = (rs1 < rs2);
        3'd7: c = (rs1 >= rs2);
        default: c = 0;
      endcase
      m_ill = ex_branch && (ex_funct3 == 3'd2 || ex_funct3 == 3'd3);
      if (ex_branch && !ex_jump && m_br != CMAX) m_br = m_br + 1'b1;
      tk = ex_jump || (ex_branch && c);
      if (tk) begin
        if (ex_target[1:0] == 2'b00) begin
          m_redir = 1;
          m_pc = ex_target;
          if (m_tk != CMAX) m_tk = m_tk + 1'b1;
        end else begin
          m_mis = 1;
        end
      end
    end
  endtask

  task automatic drive(input bit v, input bit b, input bit j, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] bb, input logic [31:0] t,
                       input bit rdy);
    ex_valid = v; ex_branch = b; ex_jump = j; ex_funct3 = f;
    rs1 = a; rs2 = bb; ex_target = t; redirect_ready = rdy;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic test_reset();
    rst = 1;
    drive(0, 0, 0, 3'd0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (dut_vec() !== 53'd0) begin
      errors++; $display("FAIL reset_state: got %h want 0", dut_vec());
    end
    rst = 0;
    model_reset();
  endtask

  task automatic test_beq();
    drive(1, 1, 0, 3'd0, 32'd7, 32'd7, 32'h100, 1);
    cycle();
    checks++;
    if (dut_vec() !== {1'b1, 32'h100, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1, 8'd1}) begin
      errors++; $display("FAIL beq_redirect: got %h want rv=1 pc=100 fl=1 br=1 tk=1", dut_vec());
    end
    drive(0, 0, 0, 3'd0, 0, 0, 0, 1);
    cycle();
    checks++;
    if (redirect_valid !== 1'b0 || flush_if_id !== 1'b0 || dut_vec() !== model_vec()) begin
      errors++; $display("FAIL beq_handshake: got %h want %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_conditions();
    logic [CNT_W-1:0] br0;
    drive(1, 1, 0, 3'd4, 32'hFFFF_FFFB, 32'd3, 32'h200, 1);
    cycle();
    checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h200 || dut_vec() !== model_vec()) begin
      errors++; $display("FAIL blt_taken: got %h want rv=1 pc=200", dut_vec());
    end
    drive(0, 0, 0, 3'd0, 0, 0, 0, 1);
    cycle();
    br0 = br_count;
    drive(1, 1, 0, 3'd6, 32'hFFFF_FFFB, 32'd3, 32'h300, 1);
    cycle();
    checks++;
    if (redirect_valid !== 1'b0 || br_count !== br0 + 1'b1 || dut_vec() !== model_vec()) begin
      errors++; $display("FAIL bltu_not_taken: got %h want %h", dut_vec(), model_vec());
    end
    drive(1, 1, 0, 3'd5, 32'h8000_0000, 32'd1, 32'h300, 1);
    cycle();
    checks++;
    if (redirect_valid !== 1'b0 || dut_vec() !== model_vec()) begin
      errors++; $display("FAIL bge_overflow: got %h want %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_hold();
    logic [CNT_W-1:0] br0;
    drive(1, 0, 1, 3'd0, 0, 0, 32'h2000, 0);
    cycle();
    br0 = br_count;
    checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h2000 || flush_id_ex !== 1'b1) begin
      errors++; $display("FAIL jal_redirect: got %h want rv=1 pc=2000", dut_vec());
    end
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 3'd0, 32'd9, 32'd9, 32'h3000, 0);
      cycle();
      checks++;
      if (redirect_valid !== 1'b1 || redirect_pc !== 32'h2000 || flush_if_id !== 1'b1 ||
          flush_id_ex !== 1'b1 || br_count !== br0 || dut_vec() !== model_vec()) begin
        errors++; $display("FAIL hold_%0d: got %h want %h", i, dut_vec(), model_vec());
      end
    end
    drive(1, 1, 0, 3'd0, 32'd9, 32'd9, 32'h3000, 1);
    cycle();
    checks++;
    if (redirect_valid !== 1'b0 || flush_if_id !== 1'b0 || br_count !== br0 ||
        dut_vec() !== model_vec()) begin
      errors++; $display("FAIL hold_release: got %h want %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_misalign_illegal();
    logic [CNT_W-1:0] tk0;
    tk0 = taken_count;
    drive(1, 1, 0, 3'd0, 32'd4, 32'd4, 32'h102, 1);
    cycle();
    checks++;
    if (misalign_err !== 1'b1 || redirect_valid !== 1'b0 || taken_count !== tk0) begin
      errors++; $display("FAIL misalign_pulse: got %h want mis=1 rv=0", dut_vec());
    end
    drive(0, 0, 0, 3'd0, 0, 0, 0, 1);
    cycle();
    checks++;
    if (misalign_err !== 1'b0 || dut_vec() !== model_vec()) begin
      errors++; $display("FAIL misalign_clear: got %h want %h", dut_vec(), model_vec());
    end
    drive(1, 1, 0, 3'd2, 32'd4, 32'd4, 32'h400, 1);
    cycle();
    checks++;
    if (illegal_br !== 1'b1 || redirect_valid !== 1'b0 || dut_vec() !== model_vec()) begin
      errors++; $display("FAIL illegal_pulse: got %h want %h", dut_vec(), model_vec());
    end
    drive(0, 0, 0, 3'd0, 0, 0, 0, 1);
    cycle();
    checks++;
    if (illegal_br !== 1'b0) begin
      errors++; $display("FAIL illegal_clear: got %b want 0", illegal_br);
    end
  endtask

  task automatic test_back_to_back();
    drive(1, 0, 1, 3'd0, 0, 0, 32'h500, 1);
    cycle();
    drive(1, 0, 1, 3'd0, 0, 0, 32'h700, 1);
    cycle();
    checks++;
    if (redirect_valid !== 1'b0 || dut_vec() !== model_vec()) begin
      errors++; $display("FAIL b2b_handshake: got %h want %h", dut_vec(), model_vec());
    end
    drive(1, 0, 1, 3'd0, 0, 0, 32'h600, 1);
    cycle();
    checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h600 || dut_vec() !== model_vec()) begin
      errors++; $display("FAIL b2b_second: got %h want rv=1 pc=600", dut_vec());
    end
    drive(0, 0, 0, 3'd0, 0, 0, 0, 1);
    cycle();
  endtask

  task automatic test_random();
    logic [31:0] a, b, t;
    for (int i = 0; i < 400; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      t = {$urandom_range(0, 32'hFFFF), 14'd0, 2'b00};
      if ($urandom_range(0, 4) == 0) t[1:0] = 2'($urandom_range(1, 3));
      drive(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 1)),
            bit'($urandom_range(0, 5) == 0), 3'($urandom_range(0, 7)), a, b, t,
            bit'($urandom_range(0, 2) != 0));
      cycle();
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL random_%0d: got %h want %h", i, dut_vec(), model_vec());
      end
    end
    drive(0, 0, 0, 3'd0, 0, 0, 0, 1);
    cycle();
    cycle();
  endtask

  task automatic test_reset_mid();
    drive(1, 0, 1, 3'd0, 0, 0, 32'h800, 0);
    cycle();
    rst = 1;
    #1;
    checks++;
    if (redirect_valid !== 1'b0 || flush_if_id !== 1'b0 || flush_id_ex !== 1'b0 ||
        br_count !== '0 || taken_count !== '0) begin
      errors++; $display("FAIL reset_mid_redirect: got %h want rv=0 fl=0 cnt=0", dut_vec());
    end
    drive(0, 0, 0, 3'd0, 0, 0, 0, 1);
    @(posedge clk);
    #1;
    rst = 0;
    model_reset();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 300; i++) begin
      drive(1, 1, 0, 3'd0, 32'd1, 32'd1, 32'h40, 1);
      cycle();
      drive(0, 0, 0, 3'd0, 0, 0, 0, 1);
      cycle();
    end
    checks++;
    if (br_count !== CMAX || taken_count !== CMAX || dut_vec() !== model_vec()) begin
      errors++; $display("FAIL saturation: got br=%h tk=%h want %h", br_count, taken_count, CMAX);
    end
    drive(1, 1, 0, 3'd0, 32'd1, 32'd1, 32'h40, 1);
    cycle();
    checks++;
    if (br_count !== CMAX || taken_count !== CMAX) begin
      errors++; $display("FAIL saturation_hold: got br=%h tk=%h want %h", br_count, taken_count, CMAX);
    end
  endtask

  initial begin
    test_reset();
    test_beq();
    test_conditions();
    test_hold();
    test_misalign_illegal();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Execute-stage consumer of the ALU status flags (zero, negative, overflow, carry) produced by a SUB of rs1 - rs2.
- Evaluates RISC-V conditional branches and jumps, then issues a registered PC redirect to fetch with a valid/ready handshake.
- Flushes wrong-path IF/ID and ID/EX contents and keeps saturating branch statistics.
- The pipeline is predict-not-taken, so every taken branch or jump redirects.

Parameters:
- XLEN, 32, width of PC and target.
- CNT_W, 16, width of each statistics counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- ex_valid  in  1  valid instruction in EX this cycle.
- ex_branch  in  1  instruction is a conditional branch.
- ex_jump  in  1  instruction is JAL/JALR (unconditional).
- ex_funct3  in  3  branch type: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
- zero, negative, overflow, carry  in  1 each  ALU flags from rs1 - rs2.
- ex_target  in  XLEN  computed branch/jump target.
- redirect_valid  out  1  redirect request to fetch.
- redirect_ready  in  1  fetch accepts the redirect.
- redirect_pc  out  XLEN  new PC.
- flush_if_id  out  1  squash IF/ID register.
- flush_id_ex  out  1  squash ID/EX register.
- misalign_err  out  1  one-cycle pulse: taken target not 4-byte aligned.
- illegal_br  out  1  one-cycle pulse: ex_branch with funct3 010 or 011.
- br_count  out  CNT_W  number of resolved conditional branches.
- taken_count  out  CNT_W  number of redirects issued.

Behaviour:
- Reset: state IDLE; all outputs 0; counters 0. Reset mid-redirect drops the request immediately (asynchronous).
- Condition decode, using SUB flag semantics:
  - EQ = zero; NE = ~zero.
  - LT = negative ^ overflow; GE = ~LT.
  - LTU = ~carry, since carry = no-borrow; GEU = carry.
- take = ex_valid & (ex_jump | (ex_branch & cond)). If both ex_jump and ex_branch are set, ex_jump wins and the branch is not counted.
- States:
  - IDLE: on take with ex_target[1:0] == 00, load redirect_pc <= ex_target and go to REDIRECT. Outputs are registered, so redirect_valid rises the cycle after the EX decision (latency 1).
  - IDLE, take with misaligned target: no redirect, stay IDLE, misalign_err = 1 on the next cycle for exactly 1 cycle.
  - REDIRECT: redirect_valid = 1 and redirect_pc is held stable until the handshake.
    - flush_if_id = flush_id_ex = 1 every cycle in REDIRECT.
    - ex_valid is ignored because those instructions are wrong-path: no counting, no new decisions, no error pulses.
  - REDIRECT & redirect_ready: handshake completes that cycle; next cycle is IDLE with redirect_valid = 0 and flushes = 0.
- Back-to-back: an EX-valid take in the first IDLE cycle after a handshake is evaluated normally.
- Counters:
  - br_count increments on ex_valid & ex_branch & ~ex_jump in IDLE, taken or not, including illegal funct3.
  - taken_count increments on the IDLE -> REDIRECT transition.
  - Both saturate at all-ones and never wrap.
- illegal_br: ex_valid & ex_branch & funct3 in {010, 011} in IDLE gives a 1-cycle pulse on the next cycle. The branch is treated as not taken.
- All outputs are driven from flops; there is no combinational path from inputs to outputs.

Decomposition:
- Shared package: funct3 branch encodings (BR_EQ..BR_GEU), state encoding (ST_IDLE, ST_REDIRECT), XLEN default.
- One natural sub-module: branch_cond_eval, a combinational flag+funct3 -> cond/illegal block, reusable by a future early-branch unit.
- FSM, counters and the output register live in the top module.

Test Plan:
- BEQ, funct3 000, zero=1, target 0x0000_0100, redirect_ready=1 -> next cycle redirect_valid=1, redirect_pc=0x100, both flushes=1 for 1 cycle; br_count=1, taken_count=1.
- BLT, rs1=-5, rs2=3 (negative=1, overflow=0) -> taken. BLTU, rs1=0xFFFF_FFFB, rs2=3 (carry=1) -> not taken, no redirect, br_count increments only.
- BGE overflow case, rs1=0x8000_0000, rs2=1 (negative=0, overflow=1) -> LT=1, BGE not taken.
- redirect_ready held 0 for 3 cycles after a taken JAL to 0x2000:
  - redirect_valid and redirect_pc=0x2000 held stable; flushes=1 for 4 cycles.
  - ex_valid branches presented during the hold are not counted.
  - Returns to IDLE after ready=1.
- Taken branch to 0x0000_0102 -> misalign_err pulse for 1 cycle, no redirect_valid, taken_count unchanged. funct3=010 branch -> illegal_br pulse, not taken.
- Assert rst while in REDIRECT -> redirect_valid and flushes drop immediately, counters clear. Force counters to all-ones -> further events leave them at 0xFFFF.
